arm_multicycle_controller: RTL and testbench

ARM_MULTICYCLE_CONTROLLER -- requirements
Module: arm_multicycle_controller

---
 rtl/arm_multicycle_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : arm_multicycle_controller
// Purpose  : Moore-style control FSM for a multicycle ARM datapath. Sequences
//            fetch/decode/memory/data-processing/branch instructions, decodes
//            the ALU operation, evaluates ARM condition codes against an
//            internal NZCV register and gates all architectural writes.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-high
//            Instr      - instruction held in the datapath IR
//            ALUFlags   - NZCV from the ALU (N=[3] .. V=[0])
//            PCWrite, IRWrite, RegWrite, MemWrite - write enables
//            AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
//            ALUControl (00 add, 01 sub, 10 and, 11 orr) - datapath selects
//            Link       - selects PC+4 into R14 for BL
// Config   : define ARM_BL_LINK_EN to enable branch-with-link register write.
// Revision : 1.0 - initial release
// ============================================================================
module arm_multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic        Link,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q,  cond_d;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic       w_rd_pc;
    logic       w_condex;
    logic [1:0] w_dp_alu;
    logic       w_cmd_known;
    logic       w_cmd_cv;
    logic       w_cmd_writes;
    logic       w_bl;
    logic       w_unused;

    assign w_cond   = Instr[31:28];
    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[25:20];
    assign w_cmd    = w_funct[4:1];
    assign w_rd_pc  = (Instr[15:12] == 4'hF);
    assign w_unused = &{1'b0, Instr[19:16], Instr[11:0]};

    // These selects depend only on the instruction class, not on state.
    assign ImmSrc = w_op;
    assign RegSrc = {(w_op == 2'b01), (w_op == 2'b10)};

    // Condition evaluation against the stored flags (N Z C V).
    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = flags_q[2];
            4'b0001: w_condex = ~flags_q[2];
            4'b0010: w_condex = flags_q[1];
            4'b0011: w_condex = ~flags_q[1];
            4'b0100: w_condex = flags_q[3];
            4'b0101: w_condex = ~flags_q[3];
            4'b0110: w_condex = flags_q[0];
            4'b0111: w_condex = ~flags_q[0];
            4'b1000: w_condex = flags_q[1] & ~flags_q[2];
            4'b1001: w_condex = ~flags_q[1] | flags_q[2];
            4'b1010: w_condex = (flags_q[3] == flags_q[0]);
            4'b1011: w_condex = (flags_q[3] != flags_q[0]);
            4'b1100: w_condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: w_condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // Data-processing command decode. cmp subtracts but never writes back;
    // unrecognised commands fall back to add with writes and flags blocked.
    always_comb begin
        w_dp_alu     = 2'b00;
        w_cmd_known  = 1'b1;
        w_cmd_cv     = 1'b0;
        w_cmd_writes = 1'b1;
        case (w_cmd)
            4'b0100: begin w_dp_alu = 2'b00; w_cmd_cv = 1'b1; end
            4'b0010: begin w_dp_alu = 2'b01; w_cmd_cv = 1'b1; end
            4'b0000: w_dp_alu = 2'b10;
            4'b1100: w_dp_alu = 2'b11;
            4'b1010: begin
                w_dp_alu     = 2'b01;
                w_cmd_cv     = 1'b1;
                w_cmd_writes = 1'b0;
            end
            default: begin
                w_dp_alu     = 2'b00;
                w_cmd_known  = 1'b0;
                w_cmd_writes = 1'b0;
            end
        endcase
    end

`ifdef ARM_BL_LINK_EN
    assign w_bl = (state_q == S_BRANCH) && Instr[24] && cond_q;
`else
    assign w_bl = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b00:   state_d = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = w_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Flags and condition latch. The condition result is frozen at the end
    // of DECODE so later states are unaffected by a flag update in ALUWB.
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_ALUWB) && w_funct[0] && cond_q && w_cmd_known) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (w_cmd_cv) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
        cond_d = (state_q == S_DECODE) ? w_condex : cond_q;
    end

    // Moore outputs; all write enables are blocked while reset is asserted.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        Link       = w_bl;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_funct[3] ? 2'b00 : 2'b01;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_q;
                PCWrite   = cond_q & w_rd_pc;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_q;
            end
            S_EXECR: ALUControl = w_dp_alu;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_alu;
            end
            S_ALUWB: begin
                ResultSrc  = 2'b00;
                ALUControl = w_dp_alu;
                RegWrite   = cond_q & w_cmd_writes;
                PCWrite    = cond_q & w_rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_q;
                RegWrite  = w_bl;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Link     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_multicycle_controller
// Purpose  : Self-checking bench for arm_multicycle_controller: directed
//            instruction table, mid-instruction reset, random instructions
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Link;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    arm_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .Link       (Link),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

`ifdef ARM_BL_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] m_flags;
    int obs_rw, obs_mw, obs_pcw;

    // {PCWrite,IRWrite,RegWrite,MemWrite,Link,AdrSrc,ALUSrcA,ALUSrcB,
    //  ResultSrc,ALUControl,ImmSrc,RegSrc}
    logic [16:0] act;
    assign act = {PCWrite, IRWrite, RegWrite, MemWrite, Link, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  af;
        int          rw;
        int          mw;
        int          pcw;
        logic [3:0]  flags;
    } vec_t;

    vec_t vt[14];

    // ARM conditions come in true/inverted pairs selected by cond[0].
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    // 0 unknown, 1 add, 2 sub, 3 and, 4 orr, 5 cmp
    function automatic int dp_kind(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 1;
            4'b0010: return 2;
            4'b0000: return 3;
            4'b1100: return 4;
            4'b1010: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] kind_alu(input int k);
        case (k)
            2, 5:    return 2'b01;
            3:       return 2'b10;
            4:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic expect_step(input int st, input logic [31:0] ins, input bit pass,
                               output logic [16:0] e, output logic [16:0] m);
        logic [1:0] op;
        int         kind;
        bit         rd15;
        op   = ins[27:26];
        kind = dp_kind(ins[24:21]);
        rd15 = (ins[15:12] == 4'hF);
        e = '0;
        m = '0;
        m[16:12] = '1;
        m[3:0]   = '1;
        e[3:2]   = op;
        e[1]     = (op == 2'b01);
        e[0]     = (op == 2'b10);
        case (st)
            0, 1: begin
                m[10:4] = '1;
                e[10] = 1'b1; e[9:8] = 2'b10; e[7:6] = 2'b10; e[5:4] = 2'b00;
                if (st == 0) begin
                    m[11] = 1'b1; e[16] = 1'b1; e[15] = 1'b1;
                end
            end
            2: begin
                m[10:8] = '1; m[5:4] = '1;
                e[9:8] = 2'b01; e[5:4] = ins[23] ? 2'b00 : 2'b01;
            end
            3: begin m[11] = 1'b1; e[11] = 1'b1; end
            4: begin
                m[7:6] = '1; e[7:6] = 2'b01;
                e[14] = pass; e[16] = pass && rd15;
            end
            5: begin m[11] = 1'b1; e[11] = 1'b1; e[13] = pass; end
            6, 7: begin
                m[10:8] = '1; m[5:4] = '1;
                e[9:8] = (st == 7) ? 2'b01 : 2'b00;
                e[5:4] = kind_alu(kind);
            end
            8: begin
                m[7:6] = '1; e[7:6] = 2'b00;
                e[14] = pass && (kind != 0) && (kind != 5);
                e[16] = pass && rd15;
            end
            default: begin
                m[10:4] = '1;
                e[9:8] = 2'b01; e[7:6] = 2'b10; e[5:4] = 2'b00;
                e[16] = pass;
                e[14] = LINK_EN && ins[24] && pass;
                e[12] = LINK_EN && ins[24] && pass;
            end
        endcase
    endtask

    // One clock cycle: drive at negedge, check 1 ns later, return after posedge.
    task automatic step(input int st, input logic [31:0] drv, input logic [3:0] af,
                        input bit pass);
        logic [16:0] e, m;
        @(negedge clk);
        Instr = drv;
        ALUFlags = af;
        #1;
        expect_step(st, drv, pass, e, m);
        total++;
        if (((act ^ e) & m) !== 17'd0) begin
            bad++;
            $display("FAIL outputs st=%0d instr=%h actual=%h required=%h care=%h",
                     st, drv, act, e, m);
        end
        total++;
        if (dut.state_q !== 4'(st)) begin
            bad++;
            $display("FAIL state instr=%h actual=%0d required=%0d", drv, dut.state_q, st);
        end
        if (RegWrite) obs_rw++;
        if (MemWrite) obs_mw++;
        if (PCWrite)  obs_pcw++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
        int         seq[$];
        bit         pass;
        logic [1:0] op;
        int         kind;
        pass = cond_ok(ins[31:28], m_flags);
        op   = ins[27:26];
        kind = dp_kind(ins[24:21]);
        seq  = '{0, 1};
        if (op == 2'b01) begin
            seq.push_back(2);
            if (ins[20]) begin seq.push_back(3); seq.push_back(4); end
            else seq.push_back(5);
        end else if (op == 2'b00) begin
            seq.push_back(ins[25] ? 7 : 6);
            seq.push_back(8);
        end else if (op == 2'b10) begin
            seq.push_back(9);
        end
        obs_rw = 0; obs_mw = 0; obs_pcw = 0;
        // The FETCH-cycle instruction value is irrelevant, so drive garbage.
        foreach (seq[k]) step(seq[k], (k == 0) ? $urandom : ins, af, pass);
        if (op == 2'b00 && pass && ins[20] && kind != 0) begin
            m_flags[3:2] = af[3:2];
            if (kind == 1 || kind == 2 || kind == 5) m_flags[1:0] = af[1:0];
        end
        total++;
        if (dut.flags_q !== m_flags) begin
            bad++;
            $display("FAIL flags instr=%h actual=%b required=%b", ins, dut.flags_q, m_flags);
        end
    endtask

    initial begin
        vt[0]  = '{32'hE0821003, 4'b0000, 1, 0, 1, 4'b0000};  // ADD R1,R2,R3
        vt[1]  = '{32'hE5910004, 4'b0000, 1, 0, 1, 4'b0000};  // LDR R0,[R1,#4]
        vt[2]  = '{32'hE0500000, 4'b0100, 1, 0, 1, 4'b0100};  // SUBS R0,R0,R0
        vt[3]  = '{32'h1AFFFFFE, 4'b0000, 0, 0, 1, 4'b0100};  // BNE, not taken
        vt[4]  = '{32'hE1500000, 4'b0000, 0, 0, 1, 4'b0000};  // CMP
        vt[5]  = '{32'h05810000, 4'b0000, 0, 0, 1, 4'b0000};  // STREQ, Z=0
        vt[6]  = '{32'hEC000000, 4'b0000, 0, 0, 1, 4'b0000};  // op=11
        vt[7]  = '{32'hEB000001, 4'b0000, LINK_EN ? 1 : 0, 0, 2, 4'b0000}; // BL
        vt[8]  = '{32'hE591F000, 4'b0000, 1, 0, 2, 4'b0000};  // LDR PC
        vt[9]  = '{32'hE0300000, 4'b1111, 0, 0, 1, 4'b0000};  // EORS (unknown)
        vt[10] = '{32'hE1900000, 4'b1111, 1, 0, 1, 4'b1100};  // ORRS: NZ only
        vt[11] = '{32'hE5010004, 4'b0000, 0, 1, 1, 4'b1100};  // STR U=0
        vt[12] = '{32'hC0900000, 4'b0011, 0, 0, 1, 4'b1100};  // ADDGTS fails
        vt[13] = '{32'hE0900000, 4'b0011, 1, 0, 1, 4'b0011};  // ADDS

        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, Link} !== 5'b0 ||
            dut.state_q !== 4'd0 || dut.flags_q !== 4'd0 || dut.cond_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_state actual=%b/%0d/%b/%b required=00000/0/0000/0",
                     {PCWrite, IRWrite, RegWrite, MemWrite, Link}, dut.state_q,
                     dut.flags_q, dut.cond_q);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_flags = 4'b0000;

        for (int i = 0; i < 14; i++) begin
            run_instr(vt[i].instr, vt[i].af);
            total++;
            if (obs_rw !== vt[i].rw || obs_mw !== vt[i].mw || obs_pcw !== vt[i].pcw ||
                dut.flags_q !== vt[i].flags) begin
                bad++;
                $display("FAIL vec%0d actual rw=%0d mw=%0d pcw=%0d fl=%b required rw=%0d mw=%0d pcw=%0d fl=%b",
                         i, obs_rw, obs_mw, obs_pcw, dut.flags_q,
                         vt[i].rw, vt[i].mw, vt[i].pcw, vt[i].flags);
            end
        end

        // Reset for two cycles while an LDR sits in MEMRD.
        obs_rw = 0; obs_mw = 0; obs_pcw = 0;
        step(0, 32'hE5910004, 4'h0, 1'b1);
        step(1, 32'hE5910004, 4'h0, 1'b1);
        step(2, 32'hE5910004, 4'h0, 1'b1);
        @(negedge clk);
        reset = 1'b1; #1;
        total++;
        if (dut.state_q !== 4'd3 || {PCWrite, IRWrite, RegWrite, MemWrite, Link} !== 5'b0) begin
            bad++;
            $display("FAIL rst_memrd actual st=%0d en=%b required st=3 en=00000",
                     dut.state_q, {PCWrite, IRWrite, RegWrite, MemWrite, Link});
        end
        @(negedge clk); #1;
        total++;
        if (dut.state_q !== 4'd0 || dut.flags_q !== 4'd0 ||
            {PCWrite, IRWrite, RegWrite, MemWrite, Link} !== 5'b0) begin
            bad++;
            $display("FAIL rst_hold actual st=%0d fl=%b en=%b required st=0 fl=0000 en=00000",
                     dut.state_q, dut.flags_q, {PCWrite, IRWrite, RegWrite, MemWrite, Link});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_flags = 4'b0000;
        total++;
        if (obs_rw !== 0) begin
            bad++;
            $display("FAIL rst_regwrite actual=%0d required=0", obs_rw);
        end
        run_instr(32'hE0821003, 4'h0);

        // Random instructions against the reference model.
        for (int i = 0; i < 400; i++) begin
            run_instr($urandom, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
